// File: rtl/pixel_readout.sv
// Pixel readout: captures a parallel frame of pixel values and streams it out one pixel
// per valid/ready transfer. An active buffer feeds the output and a shadow buffer holds
// the next frame, so a new conversion can land while the current frame is still draining.
module pixel_readout #(
    parameter int NUM_PIXELS = 4,
    parameter int DATA_W     = 8,
    parameter int IDX_W      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         capture,
    input  logic [NUM_PIXELS*DATA_W-1:0] pixel_data,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_index,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun,
    output logic [7:0]                   frame_count
);

    typedef enum logic {
        StIdle,
        StStream
    } state_t;

    localparam int FRAME_W = NUM_PIXELS * DATA_W;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic               shadow_full_q, shadow_full_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         frame_count_q, frame_count_d;

    logic transfer;
    logic is_last;

    assign transfer = (state_q == StStream) && out_ready;
    assign is_last  = (index_q == IDX_W'(NUM_PIXELS - 1));

    // Next-state: buffer hand-off, index advance, overrun detection and frame counting.
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        index_d       = index_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    active_d = pixel_data;
                    index_d  = '0;
                    state_d  = StStream;
                end
            end
            StStream: begin
                if (transfer && is_last) begin
                    frame_count_d = frame_count_q + 8'd1;
                    index_d       = '0;
                    if (shadow_full_q) begin
                        // Shadow moves up; a coincident capture refills the shadow slot.
                        active_d = shadow_q;
                        if (capture) begin
                            shadow_d = pixel_data;
                        end else begin
                            shadow_full_d = 1'b0;
                        end
                    end else if (capture) begin
                        active_d = pixel_data;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (transfer) begin
                        index_d = index_q + 1'b1;
                    end
                    if (capture) begin
                        if (!shadow_full_q) begin
                            shadow_d      = pixel_data;
                            shadow_full_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Output pixel is selected from next-state values so it is a plain register output.
        data_d = active_d[int'(index_d) * DATA_W +: DATA_W];
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            index_q       <= '0;
            data_q        <= '0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            index_q       <= index_d;
            data_q        <= data_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_valid   = (state_q == StStream);
    assign out_data    = data_q;
    assign out_index   = index_q;
    assign out_first   = out_valid && (index_q == '0);
    assign out_last    = out_valid && is_last;
    assign busy        = out_valid || shadow_full_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: table-driven cycle vectors for the basic streaming,
// backpressure and double-buffer cases, then hand-written sequences for the corner cases.
module tb_pixel_readout;

    localparam logic [31:0] FA = 32'h44332211;
    localparam logic [31:0] FB = 32'hDDCCBBAA;
    localparam logic [31:0] FC = 32'h04030201;

    logic        clk;
    logic        reset;
    logic        capture;
    logic [31:0] pixel_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_index;
    logic        out_first;
    logic        out_last;
    logic        busy;
    logic        overrun;
    logic [7:0]  frame_count;

    int n_cmp  = 0;
    int n_fail = 0;

    pixel_readout #(
        .NUM_PIXELS(4),
        .DATA_W    (8),
        .IDX_W     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .pixel_data (pixel_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_first  (out_first),
        .out_last   (out_last),
        .busy       (busy),
        .overrun    (overrun),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cap;
        logic [31:0] pd;
        logic        rdy;
        logic        v;
        logic [7:0]  d;
        logic [1:0]  i;
        logic        b;
        logic [7:0]  fc;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic cap, input logic [31:0] pd, input logic rdy, input logic v,
                       input logic [7:0] d, input logic [1:0] i, input logic b,
                       input logic [7:0] fc);
        row_t r;
        r.cap = cap; r.pd = pd; r.rdy = rdy; r.v = v; r.d = d; r.i = i; r.b = b; r.fc = fc;
        tbl.push_back(r);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs; data/index are don't-care while out_valid=0 unless full is set.
    task automatic check(input string name, input logic v, input logic [7:0] d,
                         input logic [1:0] i, input logic b, input logic o,
                         input logic [7:0] fc, input logic full);
        logic [22:0] act;
        logic [22:0] exp;
        act = {out_valid, out_data, out_index, out_first, out_last, busy, overrun, frame_count};
        exp = {v, d, i, v && (i == 2'd0), v && (i == 2'd3), b, o, fc};
        if (!v && !full) begin
            act[21:12] = '0;
            exp[21:12] = '0;
        end
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h i=%0d f=%b l=%b busy=%b ovr=%b fc=%0d, want v=%b d=%h i=%0d f=%b l=%b busy=%b ovr=%b fc=%0d",
                     name, act[22], act[21:14], act[13:12], act[11], act[10], act[9], act[8],
                     act[7:0], exp[22], exp[21:14], exp[13:12], exp[11], exp[10], exp[9],
                     exp[8], exp[7:0]);
        end
    endtask

    // One cycle: check outputs visible now, then drive inputs for the coming edge.
    task automatic cyc(input string name, input logic cap, input logic [31:0] pd,
                       input logic rdy, input logic v, input logic [7:0] d, input logic [1:0] i,
                       input logic b, input logic o, input logic [7:0] fc);
        check(name, v, d, i, b, o, fc, 1'b0);
        capture    = cap;
        pixel_data = pd;
        out_ready  = rdy;
        step();
        capture = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        capture    = 1'b0;
        pixel_data = '0;
        out_ready  = 1'b0;
        #3;
        check("reset", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1);
        step();
        step();
        reset = 1'b1;

        // single frame, ready=1
        add(1, FA, 1, 0, 8'h00, 0, 0, 0);
        add(0, 0,  1, 1, 8'h11, 0, 1, 0);
        add(0, 0,  1, 1, 8'h22, 1, 1, 0);
        add(0, 0,  1, 1, 8'h33, 2, 1, 0);
        add(0, 0,  1, 1, 8'h44, 3, 1, 0);
        add(0, 0,  1, 0, 8'h00, 0, 0, 1);
        // backpressure 1,0,0,1,1,0,1
        add(1, FA, 1, 0, 8'h00, 0, 0, 1);
        add(0, 0,  1, 1, 8'h11, 0, 1, 1);
        add(0, 0,  0, 1, 8'h22, 1, 1, 1);
        add(0, 0,  0, 1, 8'h22, 1, 1, 1);
        add(0, 0,  1, 1, 8'h22, 1, 1, 1);
        add(0, 0,  1, 1, 8'h33, 2, 1, 1);
        add(0, 0,  0, 1, 8'h44, 3, 1, 1);
        add(0, 0,  1, 1, 8'h44, 3, 1, 1);
        add(0, 0,  0, 0, 8'h00, 0, 0, 2);
        // double buffer: B captured at A index 1
        add(1, FA, 1, 0, 8'h00, 0, 0, 2);
        add(0, 0,  1, 1, 8'h11, 0, 1, 2);
        add(1, FB, 1, 1, 8'h22, 1, 1, 2);
        add(0, 0,  1, 1, 8'h33, 2, 1, 2);
        add(0, 0,  1, 1, 8'h44, 3, 1, 2);
        add(0, 0,  1, 1, 8'hAA, 0, 1, 3);
        add(0, 0,  1, 1, 8'hBB, 1, 1, 3);
        add(0, 0,  1, 1, 8'hCC, 2, 1, 3);
        add(0, 0,  1, 1, 8'hDD, 3, 1, 3);
        add(0, 0,  1, 0, 8'h00, 0, 0, 4);

        foreach (tbl[k]) begin
            cyc($sformatf("vec%0d", k), tbl[k].cap, tbl[k].pd, tbl[k].rdy, tbl[k].v,
                tbl[k].d, tbl[k].i, tbl[k].b, 1'b0, tbl[k].fc);
        end

        // coincident capture on last transfer with shadow full: no overrun
        cyc("cf_idle", 1, FA, 0, 0, 8'h00, 0, 0, 0, 4);
        cyc("cf_a0",   1, FB, 1, 1, 8'h11, 0, 1, 0, 4);
        cyc("cf_a1",   0, 0,  1, 1, 8'h22, 1, 1, 0, 4);
        cyc("cf_a2",   0, 0,  1, 1, 8'h33, 2, 1, 0, 4);
        cyc("cf_a3",   1, FC, 1, 1, 8'h44, 3, 1, 0, 4);
        cyc("cf_b0",   0, 0,  1, 1, 8'hAA, 0, 1, 0, 5);
        cyc("cf_b1",   0, 0,  1, 1, 8'hBB, 1, 1, 0, 5);
        cyc("cf_b2",   0, 0,  1, 1, 8'hCC, 2, 1, 0, 5);
        cyc("cf_b3",   0, 0,  1, 1, 8'hDD, 3, 1, 0, 5);
        cyc("cf_c0",   0, 0,  1, 1, 8'h01, 0, 1, 0, 6);
        cyc("cf_c1",   0, 0,  1, 1, 8'h02, 1, 1, 0, 6);
        cyc("cf_c2",   0, 0,  1, 1, 8'h03, 2, 1, 0, 6);
        cyc("cf_c3",   0, 0,  1, 1, 8'h04, 3, 1, 0, 6);
        cyc("cf_end",  0, 0,  1, 0, 8'h00, 0, 0, 0, 7);

        // coincident capture on last transfer with shadow empty: no bubble
        cyc("ce_idle", 1, FA, 1, 0, 8'h00, 0, 0, 0, 7);
        cyc("ce_a0",   0, 0,  1, 1, 8'h11, 0, 1, 0, 7);
        cyc("ce_a1",   0, 0,  1, 1, 8'h22, 1, 1, 0, 7);
        cyc("ce_a2",   0, 0,  1, 1, 8'h33, 2, 1, 0, 7);
        cyc("ce_a3",   1, FB, 1, 1, 8'h44, 3, 1, 0, 7);
        cyc("ce_b0",   0, 0,  1, 1, 8'hAA, 0, 1, 0, 8);
        cyc("ce_b1",   0, 0,  1, 1, 8'hBB, 1, 1, 0, 8);
        cyc("ce_b2",   0, 0,  1, 1, 8'hCC, 2, 1, 0, 8);
        cyc("ce_b3",   0, 0,  1, 1, 8'hDD, 3, 1, 0, 8);
        cyc("ce_end",  0, 0,  1, 0, 8'h00, 0, 0, 0, 9);

        // overrun: three captures while stalled, third is dropped
        cyc("ov_idle", 1, FA, 0, 0, 8'h00, 0, 0, 0, 9);
        cyc("ov_capb", 1, FB, 0, 1, 8'h11, 0, 1, 0, 9);
        cyc("ov_capc", 1, FC, 0, 1, 8'h11, 0, 1, 0, 9);
        cyc("ov_flag", 0, 0,  1, 1, 8'h11, 0, 1, 1, 9);
        cyc("ov_a1",   0, 0,  1, 1, 8'h22, 1, 1, 1, 9);
        cyc("ov_a2",   0, 0,  1, 1, 8'h33, 2, 1, 1, 9);
        cyc("ov_a3",   0, 0,  1, 1, 8'h44, 3, 1, 1, 9);
        cyc("ov_b0",   0, 0,  1, 1, 8'hAA, 0, 1, 1, 10);
        cyc("ov_b1",   0, 0,  1, 1, 8'hBB, 1, 1, 1, 10);
        cyc("ov_b2",   0, 0,  1, 1, 8'hCC, 2, 1, 1, 10);
        cyc("ov_b3",   0, 0,  1, 1, 8'hDD, 3, 1, 1, 10);
        cyc("ov_end",  0, 0,  1, 0, 8'h00, 0, 0, 1, 11);
        cyc("ov_lost", 0, 0,  1, 0, 8'h00, 0, 0, 1, 11);

        // asynchronous reset at index 2 with the shadow full
        cyc("rs_idle", 1, FA, 0, 0, 8'h00, 0, 0, 1, 11);
        cyc("rs_a0",   1, FB, 1, 1, 8'h11, 0, 1, 1, 11);
        cyc("rs_a1",   0, 0,  1, 1, 8'h22, 1, 1, 1, 11);
        check("rs_a2", 1'b1, 8'h33, 2'd2, 1'b1, 1'b1, 8'd11, 1'b0);
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rs_async", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1);
        step();
        step();
        #2;
        reset = 1'b1;
        step();
        cyc("rs_q0",   0, 0,  1, 0, 8'h00, 0, 0, 0, 0);
        cyc("rs_q1",   0, 0,  1, 0, 8'h00, 0, 0, 0, 0);
        cyc("rs_q2",   1, FA, 1, 0, 8'h00, 0, 0, 0, 0);
        cyc("rs_n0",   0, 0,  1, 1, 8'h11, 0, 1, 0, 0);
        cyc("rs_n1",   0, 0,  1, 1, 8'h22, 1, 1, 0, 0);
        cyc("rs_n2",   0, 0,  1, 1, 8'h33, 2, 1, 0, 0);
        cyc("rs_n3",   0, 0,  1, 1, 8'h44, 3, 1, 0, 0);
        cyc("rs_end",  0, 0,  1, 0, 8'h00, 0, 0, 0, 1);

        // frame counter wrap: 254 more frames reach 255, one more wraps to 0
        out_ready = 1'b1;
        for (int f = 0; f < 254; f++) begin
            capture    = 1'b1;
            pixel_data = FB;
            step();
            capture = 1'b0;
            repeat (4) step();
        end
        check("fc_255", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'd255, 1'b0);
        capture = 1'b1;
        step();
        capture = 1'b0;
        repeat (4) step();
        check("fc_wrap", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
